// File: rtl/rf_wb_ctrl_pkg.sv
// rf_wb_ctrl_pkg: shared register/data widths, x0 index and FIFO entry type for the writeback controller
package rf_wb_ctrl_pkg;
  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam logic [RF_AW-1:0] X0 = '0;
  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic [RF_DW-1:0] data;
  } entry_t;
endpackage

// File: rtl/rf_wb_ctrl_if.sv
// rf_wb_ctrl_if: ALU/LSU result handshakes and the register-file write port
interface rf_wb_ctrl_if
  import rf_wb_ctrl_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
);
  logic alu_valid, alu_ready, lsu_valid, lsu_ready, rf_we;
  logic [AW-1:0] alu_rd, lsu_rd, rf_adr_wrt;
  logic [DW-1:0] alu_data, lsu_data, rf_data;
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, rf_we, rf_adr_wrt, rf_data
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, rf_we, rf_adr_wrt, rf_data
  );
endinterface

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: synchronous FIFO with two ordered push ports (din0 enqueued ahead of din1), one pop and a count.
// RF_WB_BYPASS_EN adds an age-ordered view of all slots (index 0 = oldest).
module rf_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 37
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push0,
  input  logic push1,
  input  logic pop,
  input  logic [W-1:0] din0,
  input  logic [W-1:0] din1,
  output logic [W-1:0] head,
  output logic [$clog2(DEPTH):0] count,
  output logic empty,
  output logic full
`ifdef RF_WB_BYPASS_EN
  , output logic [DEPTH-1:0][W-1:0] entries
`endif
);
  localparam int L = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [L:0] wp, rp, wp1;
  assign wp1 = wp + (L+1)'(push0);
  assign count = wp - rp;
  assign empty = count == '0;
  assign full = count == (L+1)'(DEPTH);
  assign head = mem[rp[L-1:0]];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp1 + (L+1)'(push1);
      rp <= rp + (L+1)'(pop && !empty);
    end
  always_ff @(posedge clk) begin
    if (push0) mem[wp[L-1:0]] <= din0;
    if (push1) mem[wp1[L-1:0]] <= din1;
  end
`ifdef RF_WB_BYPASS_EN
  always_comb
    for (int k = 0; k < DEPTH; k++) entries[k] = mem[L'(rp + (L+1)'(k))];
`endif
endmodule

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: writeback arbiter (LSU over ALU), result FIFO and per-register pending-write scoreboard.
// RF_WB_BYPASS_EN adds forwarding of queued results to the operand check ports.
module rf_wb_ctrl
  import rf_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW = RF_DW,
  parameter int AW = RF_AW
) (
  input  logic clk,
  input  logic reset_n,
  rf_wb_ctrl_if.slave bus,
  input  logic issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic issue_sat,
  input  logic [AW-1:0] chk_srca,
  input  logic [AW-1:0] chk_srcb,
  output logic busy_srca,
  output logic busy_srcb,
`ifdef RF_WB_BYPASS_EN
  output logic fwd_hit_a,
  output logic fwd_hit_b,
  output logic [DW-1:0] fwd_data_a,
  output logic [DW-1:0] fwd_data_b,
`endif
  output logic fifo_empty,
  output logic fifo_full
);
  localparam int L = $clog2(DEPTH);
  localparam int NR = 1 << AW;
  logic [L:0] count;
  logic [L+1:0] free;
  logic [AW+DW-1:0] head;
  logic [AW-1:0] hrd;
  logic [NR-1:0][1:0] cnt;
  logic [NR-1:0] inc, dec;
  logic push_l, push_a, pop;
`ifdef RF_WB_BYPASS_EN
  logic [DEPTH-1:0][AW+DW-1:0] entries;
`endif
  assign pop = !fifo_empty;
  // the entry leaving this cycle frees its slot for an incoming one
  assign free = (L+2)'(DEPTH) - (L+2)'(count) + (L+2)'(pop);
  assign bus.lsu_ready = free != '0;
  assign bus.alu_ready = bus.lsu_valid ? free > (L+2)'(1) : free != '0;
  assign push_l = bus.lsu_valid && bus.lsu_ready && bus.lsu_rd != AW'(X0);
  assign push_a = bus.alu_valid && bus.alu_ready && bus.alu_rd != AW'(X0);
  rf_wb_fifo #(.DEPTH(DEPTH), .W(AW+DW)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push0(push_l),
    .push1(push_a),
    .pop(pop),
    .din0({bus.lsu_rd, bus.lsu_data}),
    .din1({bus.alu_rd, bus.alu_data}),
    .head(head),
    .count(count),
    .empty(fifo_empty),
    .full(fifo_full)
`ifdef RF_WB_BYPASS_EN
    , .entries(entries)
`endif
  );
  assign {hrd, bus.rf_data} = head;
  assign bus.rf_adr_wrt = hrd;
  assign bus.rf_we = pop;
  assign inc = NR'(issue_valid) << issue_rd;
  assign dec = NR'(pop) << hrd;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else
      for (int r = 1; r < NR; r++)
        if (inc[r] && !dec[r] && cnt[r] != 2'd3) cnt[r] <= cnt[r] + 2'd1;
        else if (dec[r] && !inc[r] && cnt[r] != 2'd0) cnt[r] <= cnt[r] - 2'd1;
  assign issue_sat = cnt[issue_rd] == 2'd3;
`ifdef RF_WB_BYPASS_EN
  logic [1:0][AW-1:0] chk;
  logic [1:0][L:0] nm;
  logic [1:0] hit;
  logic [1:0][DW-1:0] fd;
  assign chk = {chk_srcb, chk_srca};
  // later (younger) matches overwrite earlier ones
  always_comb begin
    hit = '0;
    fd = '0;
    nm = '0;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < DEPTH; k++)
        if ((L+1)'(k) < count && entries[k][AW+DW-1:DW] == chk[s] && chk[s] != AW'(X0)) begin
          hit[s] = 1'b1;
          fd[s] = entries[k][DW-1:0];
          nm[s] = nm[s] + (L+1)'(1);
        end
  end
  assign {fwd_hit_b, fwd_hit_a} = hit;
  assign {fwd_data_b, fwd_data_a} = fd;
  assign busy_srca = (L+1)'(cnt[chk_srca]) > nm[0];
  assign busy_srcb = (L+1)'(cnt[chk_srcb]) > nm[1];
`else
  assign busy_srca = cnt[chk_srca] != 2'd0;
  assign busy_srcb = cnt[chk_srcb] != 2'd0;
`endif
endmodule
